// File: rtl/rejunity_vga_playground_if.sv
// Tiny Tapeout tile pin bundle for the VGA playground.
// master drives the inputs, slave is the user block.
interface rejunity_vga_playground_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/rejunity_vga_playground.sv
// 640x480@60Hz VGA timing, frame counter and animated pattern.
// Output pin order matches the TinyVGA PMOD.
module rejunity_vga_playground (
  input  logic clk,
  input  logic rst_n,
  rejunity_vga_playground_if.slave tt
);

  localparam logic [9:0] HLAST  = 10'd799;
  localparam logic [9:0] VLAST  = 10'd524;
  localparam logic [9:0] HVIS   = 10'd640;
  localparam logic [9:0] VVIS   = 10'd480;
  localparam logic [9:0] HS_BEG = 10'd656;
  localparam logic [9:0] HS_END = 10'd751;
  localparam logic [9:0] VS_BEG = 10'd490;
  localparam logic [9:0] VS_END = 10'd491;

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] frame_q, frame_d;

  logic line_end, frame_end;

  always_comb begin
    line_end  = (hpos_q == HLAST);
    frame_end = line_end && (vpos_q == VLAST);
    hpos_d    = hpos_q + 10'd1;
    vpos_d    = vpos_q;
    frame_d   = frame_q;
    if (line_end) begin
      hpos_d = '0;
      vpos_d = (vpos_q == VLAST) ? '0 : vpos_q + 10'd1;
    end
    if (frame_end && !tt.ui_in[0])
      frame_d = frame_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
    end
  end

  logic       hsync, vsync, display_on;
  logic [9:0] rsum, xy;
  logic [1:0] r, g, b;
  logic [5:0] rgb;

  always_comb begin
    hsync      = !((hpos_q >= HS_BEG) && (hpos_q <= HS_END));
    vsync      = !((vpos_q >= VS_BEG) && (vpos_q <= VS_END));
    display_on = (hpos_q < HVIS) && (vpos_q < VVIS);
    rsum       = hpos_q + {2'b00, frame_q};
    xy         = hpos_q ^ vpos_q;
    rgb        = {xy[5:4], vpos_q[7:6], rsum[7:6]};
    if (tt.ui_in[1])
      rgb = ~rgb;
    // blanking overrides inversion
    if (!display_on)
      rgb = '0;
    {b, g, r} = rgb;
  end

  assign tt.uo_out  = {hsync, b[0], g[0], r[0],
                       vsync, b[1], g[1], r[1]};
  assign tt.uio_out = '0;
  assign tt.uio_oe  = '0;

  logic unused_pins;
  assign unused_pins = &{1'b0, tt.ena, tt.uio_in, tt.ui_in[7:2]};

endmodule

// File: tb/tb_rejunity_vga_playground.sv
// Bench for rejunity_vga_playground: vector table, corner
// sequences and random ui_in against a pixel-rule model.
module tb_rejunity_vga_playground;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rejunity_vga_playground_if tt ();

  rejunity_vga_playground dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt.slave)
  );

  always #20 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  int mx, my, mf;

  typedef struct {
    int         cyc;
    logic [7:0] ui;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vt[13];

  function automatic logic [7:0] model(int x, int y, int f,
                                       logic [7:0] ui);
    int r, g, b;
    bit hs, vs, on;
    hs = !(x >= 656 && x <= 751);
    vs = !(y >= 490 && y <= 491);
    on = (x < 640) && (y < 480);
    r  = (((x + f) % 1024) / 64) % 4;
    g  = (y / 64) % 4;
    b  = ((x ^ y) / 16) % 4;
    if (ui[1]) begin
      r = 3 - r;
      g = 3 - g;
      b = 3 - b;
    end
    if (!on) begin
      r = 0;
      g = 0;
      b = 0;
    end
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %02h want %02h (x=%0d y=%0d f=%0d)",
               nm, act, exp, mx, my, mf);
    end
  endtask

  task automatic chk_model(string nm);
    chk(nm, tt.uo_out, model(mx, my, mf, tt.ui_in));
  endtask

  task automatic do_reset();
    tt.ui_in = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("rst_uo", tt.uo_out, 8'h88);
    chk("rst_uio_out", tt.uio_out, 8'h00);
    chk("rst_uio_oe", tt.uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    mf = 0;
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      if (mx == 799 && my == 524 && !tt.ui_in[0])
        mf = (mf + 1) % 256;
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic jump(logic [9:0] x, logic [9:0] y);
    force dut.hpos_q = x;
    force dut.vpos_q = y;
    #1;
    release dut.hpos_q;
    release dut.vpos_q;
    mx = int'(x);
    my = int'(y);
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      tt.ui_in = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        tt.ui_in[0] = 1'b0;
      #1;
      chk_model("rand");
      step(1);
    end
  endtask

  initial begin
    tt.ena    = 1'b1;
    tt.ui_in  = 8'h00;
    tt.uio_in = 8'h00;

    vt[0]  = '{0,   8'h00, 8'h88, "px0"};
    vt[1]  = '{0,   8'h02, 8'hFF, "px0_inv"};
    vt[2]  = '{16,  8'h00, 8'hC8, "x16"};
    vt[3]  = '{64,  8'h00, 8'h98, "x64"};
    vt[4]  = '{200, 8'h02, 8'hEE, "x200_inv"};
    vt[5]  = '{639, 8'h00, 8'hDC, "x639"};
    vt[6]  = '{640, 8'h02, 8'h88, "x640_blank"};
    vt[7]  = '{655, 8'h00, 8'h88, "hs_pre"};
    vt[8]  = '{656, 8'h00, 8'h08, "hs_beg"};
    vt[9]  = '{700, 8'h02, 8'h08, "hs_inv_blank"};
    vt[10] = '{751, 8'h00, 8'h08, "hs_end"};
    vt[11] = '{752, 8'h00, 8'h88, "hs_post"};
    vt[12] = '{799, 8'h02, 8'h88, "x799"};

    foreach (vt[k]) begin
      do_reset();
      step(vt[k].cyc);
      tt.ui_in = vt[k].ui;
      #1;
      chk(vt[k].name, tt.uo_out, vt[k].exp);
    end

    do_reset();
    tt.ui_in = 8'h02;
    #1;
    chk("rst_inv", tt.uo_out, 8'hFF);
    tt.ui_in = 8'h00;

    // pixel (63,0) across a frame boundary
    do_reset();
    step(63);
    #1;
    chk("f0_px63", tt.uo_out, 8'hCC);
    jump(10'd790, 10'd524);
    step(10 + 63);
    #1;
    chk("f1_px63", tt.uo_out, 8'hDC);

    // frozen frame counter over three wraps
    do_reset();
    tt.ui_in = 8'h01;
    for (int k = 0; k < 3; k++) begin
      jump(10'd795, 10'd524);
      step(5 + 63);
      #1;
      chk("freeze_px63", tt.uo_out, 8'hCC);
    end

    // freeze only during the wrap cycle
    do_reset();
    jump(10'd798, 10'd524);
    step(1);
    tt.ui_in = 8'h01;
    step(1);
    tt.ui_in = 8'h00;
    step(63);
    #1;
    chk("freeze_last", tt.uo_out, 8'hCC);

    // vertical blanking and vsync window
    do_reset();
    jump(10'd790, 10'd478);
    for (int i = 0; i < 3000; i++) begin
      #1;
      chk_model("vblank");
      if (my >= 490 && my <= 491)
        chk("vsync_low", {7'd0, tt.uo_out[3]}, 8'h00);
      step(1);
    end

    // mid-line reset
    do_reset();
    step(300);
    rst_n = 1'b0;
    #1;
    chk("midrst", tt.uo_out, 8'h88);
    @(negedge clk);
    #1;
    chk("midrst_hold", tt.uo_out, 8'h88);
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    mf = 0;
    step(64);
    #1;
    chk("restart_x64", tt.uo_out, 8'h98);

    // random ui_in, including across frame wraps
    do_reset();
    rand_run(4000);
    for (int k = 0; k < 6; k++) begin
      jump(10'($urandom_range(780, 799)), 10'd524);
      rand_run(1500);
    end
    jump(10'd700, 10'd487);
    rand_run(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
